ssd_decoder: RTL and testbench

Seven-segment readback decoder: the inverse of the calculator's digit-to-segment encoder. It samples the multiplexed, active-low anode and cathode lines driven to the 4-digit display and filters out scan transitions. It then decodes each stable segment pattern back to its 4-bit digit code and assembles a 16-bit frame, delivered over a valid/ready handshake. It sits alongside the display path as a self-check and readback monitor for the calculator.

---
 rtl/ssd_decoder.sv | 165 ++++++++++++++++
 tb/tb_ssd_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_decoder.sv
// Seven-segment readback decoder: filters scanned anode/cathode lines, decodes digits, frames them.
// Optional unknown-pattern error pulse enabled by defining SSD_DECODER_ERR_EN.
module ssd_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        ssd_decoder_port_clk,
  input  logic        ssd_decoder_port_rst,
  input  logic [3:0]  ssd_decoder_port_an,
  input  logic [6:0]  ssd_decoder_port_cc,
  input  logic        ssd_decoder_port_frame_ready,
  output logic [15:0] ssd_decoder_port_frame,
  output logic        ssd_decoder_port_frame_valid,
  output logic        ssd_decoder_port_overrun,
  output logic        ssd_decoder_port_err
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  // Segment pattern to digit code; unknown patterns fall back to the blank code.
  function automatic logic [3:0] decode_cc(input logic [6:0] cc);
    case (cc)
      7'b0000001: decode_cc = 4'h0;
      7'b1001111: decode_cc = 4'h1;
      7'b0010010: decode_cc = 4'h2;
      7'b0000110: decode_cc = 4'h3;
      7'b1001100: decode_cc = 4'h4;
      7'b0100100: decode_cc = 4'h5;
      7'b0100000: decode_cc = 4'h6;
      7'b0001111: decode_cc = 4'h7;
      7'b0000000: decode_cc = 4'h8;
      7'b0000100: decode_cc = 4'h9;
      7'b1111111: decode_cc = 4'hA;
      7'b1100000: decode_cc = 4'hB;
      7'b0110001: decode_cc = 4'hC;
      7'b1000010: decode_cc = 4'hD;
      7'b0111010: decode_cc = 4'hE;
      7'b1011010: decode_cc = 4'hF;
      default:    decode_cc = 4'hA;
    endcase
  endfunction

  logic [3:0]  prev_an_r;
  logic [6:0]  prev_cc_r;
  logic [7:0]  cnt_r;
  logic        done_r;
  logic [15:0] slot_r;
  logic [3:0]  seen_r;
  logic [15:0] frame_r;
  logic        valid_r;
  logic        overrun_r;

  logic        sel_s;
  logic [1:0]  idx_s;
  logic        same_s;
  logic [7:0]  cnt_nxt_s;
  logic        done_nxt_s;
  logic        cap_s;
  logic [3:0]  code_s;
  logic [15:0] merged_s;
  logic [3:0]  seen_nxt_s;
  logic        complete_s;

  // Sample qualification, stability tracking and capture/merge decisions.
  always_comb begin
    sel_s      = 1'b0;
    idx_s      = 2'd0;
    cnt_nxt_s  = 8'd0;
    done_nxt_s = 1'b0;
    case (ssd_decoder_port_an)
      4'b1110: begin sel_s = 1'b1; idx_s = 2'd0; end
      4'b1101: begin sel_s = 1'b1; idx_s = 2'd1; end
      4'b1011: begin sel_s = 1'b1; idx_s = 2'd2; end
      4'b0111: begin sel_s = 1'b1; idx_s = 2'd3; end
      default: begin sel_s = 1'b0; idx_s = 2'd0; end
    endcase
    same_s = (ssd_decoder_port_an == prev_an_r) && (ssd_decoder_port_cc == prev_cc_r);
    if (!sel_s) begin
      cnt_nxt_s  = 8'd0;
      done_nxt_s = 1'b0;
    end else if (same_s) begin
      cnt_nxt_s  = (cnt_r >= STABLE_C) ? STABLE_C : cnt_r + 8'd1;
      done_nxt_s = done_r;
    end else begin
      cnt_nxt_s  = 8'd1;
      done_nxt_s = 1'b0;
    end
    cap_s    = sel_s && (cnt_nxt_s == STABLE_C) && !done_nxt_s;
    code_s   = decode_cc(ssd_decoder_port_cc);
    merged_s = slot_r;
    case (idx_s)
      2'd0:    merged_s[3:0]   = code_s;
      2'd1:    merged_s[7:4]   = code_s;
      2'd2:    merged_s[11:8]  = code_s;
      2'd3:    merged_s[15:12] = code_s;
      default: merged_s        = slot_r;
    endcase
    seen_nxt_s = seen_r | (4'b0001 << idx_s);
    complete_s = cap_s && (seen_nxt_s == 4'b1111);
  end

  // Scan tracking, slot assembly and frame handshake state.
  always_ff @(posedge ssd_decoder_port_clk or posedge ssd_decoder_port_rst) begin
    if (ssd_decoder_port_rst) begin
      prev_an_r <= 4'h0;
      prev_cc_r <= 7'h00;
      cnt_r     <= 8'd0;
      done_r    <= 1'b0;
      slot_r    <= 16'h0000;
      seen_r    <= 4'h0;
      frame_r   <= 16'h0000;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      prev_an_r <= ssd_decoder_port_an;
      prev_cc_r <= ssd_decoder_port_cc;
      cnt_r     <= cnt_nxt_s;
      done_r    <= cap_s ? 1'b1 : done_nxt_s;
      if (cap_s) begin
        slot_r <= merged_s;
        seen_r <= complete_s ? 4'h0 : seen_nxt_s;
      end else begin
        slot_r <= slot_r;
        seen_r <= seen_r;
      end
      // A completed frame is dropped rather than overwriting one still pending.
      if (complete_s) begin
        if (!valid_r || ssd_decoder_port_frame_ready) begin
          frame_r <= merged_s;
          valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && ssd_decoder_port_frame_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

`ifdef SSD_DECODER_ERR_EN
  logic err_r;
  logic unknown_s;

  assign unknown_s = (code_s == 4'hA) && (ssd_decoder_port_cc != 7'b1111111);

  // One-cycle pulse following capture of an unrecognised pattern.
  always_ff @(posedge ssd_decoder_port_clk or posedge ssd_decoder_port_rst) begin
    if (ssd_decoder_port_rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= cap_s && unknown_s;
    end
  end

  assign ssd_decoder_port_err = err_r;
`else
  assign ssd_decoder_port_err = 1'b0;
`endif

  assign ssd_decoder_port_frame       = frame_r;
  assign ssd_decoder_port_frame_valid = valid_r;
  assign ssd_decoder_port_overrun     = overrun_r;

endmodule

// File: tb/tb_ssd_decoder.sv
// Scoreboard bench for ssd_decoder: scans digit patterns, queues expected frames, checks handshake.
module tb_ssd_decoder;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  cc = 7'h7F;
  logic        ready = 1'b0;
  logic [15:0] frame;
  logic        frame_valid;
  logic        overrun;
  logic        err;

  int asserts = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  ssd_decoder #(.STABLE_CYCLES(S)) dut (
    .ssd_decoder_port_clk(clk),
    .ssd_decoder_port_rst(rst),
    .ssd_decoder_port_an(an),
    .ssd_decoder_port_cc(cc),
    .ssd_decoder_port_frame_ready(ready),
    .ssd_decoder_port_frame(frame),
    .ssd_decoder_port_frame_valid(frame_valid),
    .ssd_decoder_port_overrun(overrun),
    .ssd_decoder_port_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'b0000001; 4'h1: enc = 7'b1001111;
      4'h2: enc = 7'b0010010; 4'h3: enc = 7'b0000110;
      4'h4: enc = 7'b1001100; 4'h5: enc = 7'b0100100;
      4'h6: enc = 7'b0100000; 4'h7: enc = 7'b0001111;
      4'h8: enc = 7'b0000000; 4'h9: enc = 7'b0000100;
      4'hA: enc = 7'b1111111; 4'hB: enc = 7'b1100000;
      4'hC: enc = 7'b0110001; 4'hD: enc = 7'b1000010;
      4'hE: enc = 7'b0111010; default: enc = 7'b1011010;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    an = 4'hF;
    cc = 7'h7F;
    step();
  endtask

  task automatic show_digit(input int k, input logic [6:0] pat, input int hold);
    an = 4'hF ^ (4'b0001 << k);
    cc = pat;
    repeat (hold) step();
  endtask

  // Scans all four digits; no blanking after the last so the caller sees the completion cycle.
  task automatic scan_frame(input logic [15:0] val, input bit expect_load);
    if (expect_load) exp_q.push_back(val);
    for (int k = 0; k < 4; k++) begin
      show_digit(k, enc(val[4*k +: 4]), S);
      if (k < 3) blank();
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (frame_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    asserts++;
    if (frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: frame_valid timeout, got %b expected 1", name, frame_valid);
    end
  endtask

  task automatic pop_compare(input string name);
    asserts++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, frame got %h", name, frame);
    end else begin
      exp_v = exp_q.pop_front();
      if (frame !== exp_v) begin
        fails++;
        $display("FAIL %s: frame got %h expected %h", name, frame, exp_v);
      end
    end
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    asserts++;
    if ({frame, frame_valid, overrun, err} !== 19'h0) begin
      fails++;
      $display("FAIL %s: got frame=%h valid=%b ovr=%b err=%b expected all 0", name, frame, frame_valid, overrun, err);
    end
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    async_reset_check("reset");
    step();
  endtask

  task automatic test_full_frame();
    ready = 1'b1;
    scan_frame(16'hF312, 1'b1);
    asserts++;
    if (frame_valid !== 1'b1) begin
      fails++;
      $display("FAIL full_valid_latency: got %b expected 1", frame_valid);
    end
    pop_compare("full_frame");
    asserts++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL full_err: got %b expected 0", err);
    end
    blank();
    asserts++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_valid_fall: got %b expected 0", frame_valid);
    end
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    show_digit(0, enc(4'h7), S - 1);
    cc = enc(4'h8);
    step();
    blank();
    for (int k = 1; k < 4; k++) begin
      show_digit(k, enc(4'(k)), S);
      blank();
    end
    asserts++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL glitch_no_capture: valid got %b expected 0", frame_valid);
    end
    exp_q.push_back(16'h3214);
    show_digit(0, enc(4'h4), S);
    wait_valid("glitch_complete");
    pop_compare("glitch_frame");
    blank();
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    scan_frame(16'h0000, 1'b1);
    wait_valid("bp_first");
    pop_compare("bp_first_frame");
    blank();
    scan_frame(16'h9999, 1'b0);
    asserts++;
    if (frame !== 16'h0000 || frame_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL bp_overrun: got frame=%h valid=%b ovr=%b expected 0000 1 1", frame, frame_valid, overrun);
    end
    blank();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    asserts++;
    if (frame_valid !== 1'b0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL bp_sticky: got valid=%b ovr=%b expected 0 1", frame_valid, overrun);
    end
    scan_frame(16'h1234, 1'b1);
    wait_valid("bp_pending");
    pop_compare("bp_pending_frame");
    async_reset_check("reset_while_valid");
    step();
  endtask

  task automatic test_unknown();
    logic exp_err;
`ifdef SSD_DECODER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    ready = 1'b1;
    exp_q.push_back(16'h321A);
    show_digit(0, 7'b1111110, S);
    asserts++;
    if (err !== exp_err) begin
      fails++;
      $display("FAIL unknown_err_pulse: got %b expected %b", err, exp_err);
    end
    blank();
    asserts++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL unknown_err_width: got %b expected 0", err);
    end
    for (int k = 1; k < 4; k++) begin
      show_digit(k, enc(4'(k)), S);
      if (k < 3) blank();
    end
    wait_valid("unknown_complete");
    pop_compare("unknown_frame");
    blank();
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b1;
    show_digit(0, enc(4'h7), S);
    blank();
    show_digit(1, enc(4'h8), S);
    blank();
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    scan_frame(16'h5555, 1'b1);
    wait_valid("mid_reset_complete");
    pop_compare("mid_reset_frame");
    blank();
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    scan_frame(16'hA5C3, 1'b1);
    wait_valid("b2b_first");
    pop_compare("b2b_first_frame");
    scan_frame(16'h0BDE, 1'b1);
    wait_valid("b2b_second");
    pop_compare("b2b_second_frame");
    blank();
    asserts++;
    if (frame_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: valid got %b queue %0d expected 0 0", frame_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_glitch();
    test_backpressure();
    test_unknown();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
